// File: rtl/load_use_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_scoreboard
//  Purpose  : Detects load-use hazards between the ID-stage instruction and
//             loads still in flight. Each architectural register r != 0 owns
//             a 3-bit down-counter holding the number of cycles its pending
//             load result stays unavailable. When the ID instruction reads a
//             pending register, the PC and IF/ID register are held and a
//             bubble (all-zero control bundle) is sent into ID/EX.
//
//  Ports    : clk, arst_n        clock, asynchronous active-low reset
//             id_valid_i         ID stage holds a valid instruction
//             id_rs1_i/id_rs2_i  source registers of the ID instruction
//             id_uses_rs2_i      ID instruction reads rs2
//             id_rd_i            destination register of the ID instruction
//             id_is_load_i       ID instruction is a load
//             ctrl_i / ctrl_o    control bundle in / into ID/EX (0 = bubble)
//             flush_i            squash the ID instruction (outranks hazard)
//             stall_pc_o         hold the PC
//             stall_if_id_o      hold the IF/ID register
//             busy_o             at least one load outstanding
//             stall_cnt_clr_i    (optional) synchronous clear of stall count
//             stall_cnt_o        (optional) saturating 16-bit stall count
//
//  Options  : define LOAD_USE_SCOREBOARD_STALL_CNT_EN to add the stall
//             counter and its two ports.
//
//  Revision : 1.0  initial release
// ============================================================================
module load_use_scoreboard #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int CTRL_W       = 10
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_is_load_i,
   input  logic [CTRL_W-1:0]     ctrl_i,
   input  logic                  flush_i,
   output logic [CTRL_W-1:0]     ctrl_o,
   output logic                  stall_pc_o,
   output logic                  stall_if_id_o,
`ifdef LOAD_USE_SCOREBOARD_STALL_CNT_EN
   input  logic                  stall_cnt_clr_i,
   output logic [15:0]           stall_cnt_o,
`endif
   output logic                  busy_o
);

   localparam int          c_num_regs = 2**REG_ADDR_W;
   localparam logic [2:0]  c_load_lat = 3'(LOAD_LATENCY);

   // One "still pending" flag per register; bit 0 is the zero register and
   // can never be pending.
   logic [c_num_regs-1:0] w_pend_nz;
   logic                  w_rs1_hit;
   logic                  w_rs2_hit;
   logic                  w_hazard;
   logic                  w_issue;

   assign w_pend_nz[0] = 1'b0;

   assign w_rs1_hit = (id_rs1_i != '0) && w_pend_nz[id_rs1_i];
   assign w_rs2_hit = id_uses_rs2_i && (id_rs2_i != '0) && w_pend_nz[id_rs2_i];
   assign w_hazard  = id_valid_i && (w_rs1_hit || w_rs2_hit);

   // A load only enters the scoreboard if it actually proceeds into EX.
   assign w_issue   = id_valid_i && id_is_load_i && !w_hazard && !flush_i &&
                      (id_rd_i != '0);

   // Per-register latency counters. A new issue reloads the counter even if
   // it is still running, so a back-to-back load to the same rd restarts
   // the full latency window.
   generate
      for (genvar r = 1; r < c_num_regs; r++) begin : g_pend
         logic [2:0] r_cnt;

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               r_cnt <= 3'd0;
            end else if (w_issue && (id_rd_i == REG_ADDR_W'(r))) begin
               r_cnt <= c_load_lat;
            end else if (r_cnt != 3'd0) begin
               r_cnt <= r_cnt - 3'd1;
            end
         end

         assign w_pend_nz[r] = (r_cnt != 3'd0);
      end
   endgenerate

   // Derived from counter state only; no input reaches busy_o.
   assign busy_o = |w_pend_nz;

   always_comb begin
      ctrl_o        = ctrl_i;
      stall_pc_o    = 1'b0;
      stall_if_id_o = 1'b0;
      if (flush_i) begin
         // The squashed instruction must not hold the front end: the
         // redirect has to be fetched.
         ctrl_o = '0;
      end else if (w_hazard) begin
         ctrl_o        = '0;
         stall_pc_o    = 1'b1;
         stall_if_id_o = 1'b1;
      end
   end

`ifdef LOAD_USE_SCOREBOARD_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_stall_cnt <= 16'd0;
      end else if (stall_cnt_clr_i) begin
         r_stall_cnt <= 16'd0;
      end else if (stall_pc_o && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
